// File: rtl/pcie_host_sideband_if.sv
// pcie_host_sideband_if: slot sideband bundle between host sequencer (slave) and its environment (master)
// enable/pwr_good/clkreq_l flow into the sequencer; pwr_en/refclk_oe/perst_l/fault/state flow out.
interface pcie_host_sideband_if;
  logic       enable;
  logic       pwr_good;
  logic       clkreq_l;
  logic       pwr_en;
  logic       refclk_oe;
  logic       perst_l;
  logic       fault;
  logic [2:0] state;
  modport master (output enable, pwr_good, clkreq_l, input pwr_en, refclk_oe, perst_l, fault, state);
  modport slave (input enable, pwr_good, clkreq_l, output pwr_en, refclk_oe, perst_l, fault, state);
endinterface

// File: rtl/pcie_host_sideband.sv
// pcie_host_sideband: host-side slot power, refclk gating and PERST# sequencer
// Ports: clk, reset (sync, active-high); sb.slave carries enable, pwr_good (async), clkreq_l (async)
// in and pwr_en, refclk_oe, perst_l, fault, state out. All outputs registered from the next state.
module pcie_host_sideband #(
  parameter logic [31:0] PWR_SETTLE_CYC    = 32'd1_000_000,
  parameter logic [31:0] PWR_TIMEOUT_CYC   = 32'd10_000_000,
  parameter logic [31:0] REFCLK_SETTLE_CYC = 32'd10_000,
  parameter logic [31:0] PERST_MIN_CYC     = 32'd10_000,
  parameter logic [31:0] CLKREQ_FILT       = 32'd16,
  parameter bit          CLKREQ_USE        = 1'b1
) (
  input logic clk,
  input logic reset,
  pcie_host_sideband_if.slave sb
);
  typedef enum logic [2:0] {OFF, PWR_ON, WAIT_CLKREQ, REFCLK, RUN, PERST_HOLD, FAULT} state_t;
  state_t st, st_n;
  logic pg_m, pg, ck_m, ck, lvl, lvl_n, drop;
  logic [31:0] cnt, scnt, fcnt;
  always_comb begin
    lvl_n = (ck != lvl && fcnt == CLKREQ_FILT - 32'd1) ? ck : lvl;
    // losing enable (or power once it was qualified) beats every other transition
    drop = !sb.enable || (!pg && st inside {WAIT_CLKREQ, REFCLK, RUN});
    st_n = st;
    case (st)
      OFF:         st_n = sb.enable ? PWR_ON : OFF;
      PWR_ON:      st_n = !sb.enable ? PERST_HOLD :
                          (pg && scnt == PWR_SETTLE_CYC - 32'd1) ? (CLKREQ_USE ? WAIT_CLKREQ : REFCLK) :
                          (cnt == PWR_TIMEOUT_CYC - 32'd1) ? FAULT : PWR_ON;
      WAIT_CLKREQ: st_n = drop ? PERST_HOLD : !lvl ? REFCLK : WAIT_CLKREQ;
      REFCLK:      st_n = drop ? PERST_HOLD : (cnt == REFCLK_SETTLE_CYC - 32'd1) ? RUN : REFCLK;
      RUN:         st_n = drop ? PERST_HOLD : RUN;
      PERST_HOLD:  st_n = (cnt == PERST_MIN_CYC - 32'd1) ? OFF : PERST_HOLD;
      FAULT:       st_n = !sb.enable ? OFF : FAULT;
      default:     st_n = OFF;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      {pg_m, pg, ck_m, ck} <= '0;
      lvl          <= 1'b1;
      fcnt         <= '0;
      cnt          <= '0;
      scnt         <= '0;
      st           <= OFF;
      sb.pwr_en    <= 1'b0;
      sb.refclk_oe <= 1'b0;
      sb.perst_l   <= 1'b0;
      sb.fault     <= 1'b0;
      sb.state     <= 3'd0;
    end else begin
      pg_m         <= sb.pwr_good;
      pg           <= pg_m;
      ck_m         <= sb.clkreq_l;
      ck           <= ck_m;
      lvl          <= lvl_n;
      fcnt         <= (ck == lvl || fcnt == CLKREQ_FILT - 32'd1) ? 32'd0 : fcnt + 32'd1;
      st           <= st_n;
      cnt          <= (st_n != st) ? 32'd0 : cnt + 32'd1;
      scnt         <= (st == PWR_ON && st_n == PWR_ON && pg) ? scnt + 32'd1 : 32'd0;
      sb.pwr_en    <= st_n inside {PWR_ON, WAIT_CLKREQ, REFCLK, RUN, PERST_HOLD};
      // in RUN the refclk follows the filtered CLKREQ# on the same edge the filter accepts it
      sb.refclk_oe <= st_n == REFCLK || st_n == PERST_HOLD || (st_n == RUN && (!CLKREQ_USE || !lvl_n));
      sb.perst_l   <= st_n == RUN;
      sb.fault     <= st_n == FAULT;
      sb.state     <= st_n;
    end
  end
endmodule
